// File: rtl/label_map_packer.sv
// Reads a PIX_N-entry label map from SRAM and packs a 1-bit-per-pixel match mask into bytes.
// Optional matched-pixel counter is built only when LABEL_PIX_COUNT_EN is defined.
module label_map_packer #(
  parameter int unsigned PIX_N = 1024,
  parameter int unsigned LBL_W = 8,
  parameter int unsigned CNT_W = 11
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [LBL_W-1:0]           sel_label,
  output logic [$clog2(PIX_N)-1:0]   sram_a,
  input  logic [LBL_W-1:0]           sram_q,
  output logic [$clog2(PIX_N)-4:0]   out_a,
  output logic [7:0]                 out_d,
  output logic                       out_wen,
  output logic                       busy,
  output logic                       finish,
  output logic [CNT_W-1:0]           pix_cnt
);

  localparam int unsigned AW  = $clog2(PIX_N);
  localparam int unsigned OAW = AW - 3;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t           state_q;
  logic [LBL_W-1:0] sel_q;
  logic [7:0]       pack_q;
  logic             eval_vld_q;
  logic [AW-1:0]    eval_idx_q;

  logic             accept_c;
  logic             match_c;
  logic [7:0]       pack_d;

  // sram_q belongs to eval_idx_q whenever eval_vld_q is set
  assign accept_c = start && ((state_q == IDLE) || (state_q == DONE));
  assign match_c  = (sel_q == '0) ? (sram_q != '0) : (sram_q == sel_q);
  assign pack_d   = {match_c, pack_q[7:1]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      pack_q     <= '0;
      eval_vld_q <= 1'b0;
      eval_idx_q <= '0;
      sram_a     <= '0;
      out_a      <= '0;
      out_d      <= '0;
      out_wen    <= 1'b1;
      busy       <= 1'b0;
      finish     <= 1'b0;
    end else begin
      out_wen    <= 1'b1;
      eval_vld_q <= 1'b0;

      // Pixel n lands in bit n[2:0]; the byte is emitted once bit 7 arrives
      if (eval_vld_q) begin
        pack_q <= pack_d;
        if (eval_idx_q[2:0] == 3'd7) begin
          out_wen <= 1'b0;
          out_a   <= eval_idx_q[AW-1:3];
          out_d   <= pack_d;
        end
      end

      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= RUN;
            sram_a  <= '0;
            sel_q   <= sel_label;
            pack_q  <= '0;
            busy    <= 1'b1;
            finish  <= 1'b0;
          end
        end
        RUN: begin
          eval_vld_q <= 1'b1;
          eval_idx_q <= sram_a;
          if (sram_a == AW'(PIX_N - 1)) begin
            state_q <= FLUSH;
          end else begin
            sram_a <= sram_a + AW'(1);
          end
        end
        FLUSH: begin
          // The only write seen in FLUSH is the final byte
          if (!out_wen) begin
            state_q <= DONE;
            busy    <= 1'b0;
            finish  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef LABEL_PIX_COUNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_cnt <= '0;
    end else if (accept_c) begin
      pix_cnt <= '0;
    end else if (eval_vld_q && match_c) begin
      pix_cnt <= pix_cnt + CNT_W'(1);
    end
  end
`else
  assign pix_cnt = '0;
  logic unused_c;
  assign unused_c = accept_c;
`endif

endmodule

// File: tb/tb_label_map_packer.sv
// Self-checking bench for label_map_packer: table vectors, random frames vs a mask model, restart/reset sequences.
module tb_label_map_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  sel_label;
  logic [9:0]  sram_a;
  logic [7:0]  sram_q;
  logic [6:0]  out_a;
  logic [7:0]  out_d;
  logic        out_wen;
  logic        busy;
  logic        finish;
  logic [10:0] pix_cnt;

  label_map_packer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .sel_label (sel_label),
    .sram_a    (sram_a),
    .sram_q    (sram_q),
    .out_a     (out_a),
    .out_d     (out_d),
    .out_wen   (out_wen),
    .busy      (busy),
    .finish    (finish),
    .pix_cnt   (pix_cnt)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [1024];
  always @(posedge clk) sram_q <= mem[sram_a];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference mask: byte a bit i = match of pixel 8*a+i
  logic [7:0] exp_b [128];
  int         exp_cnt;

  task automatic model(input logic [7:0] sel);
    exp_cnt = 0;
    for (int a = 0; a < 128; a++) begin
      logic [7:0] b;
      b = 8'h00;
      for (int i = 0; i < 8; i++) begin
        logic [7:0] lbl;
        bit hit;
        lbl = mem[8*a + i];
        hit = (sel == 8'd0) ? (lbl != 8'd0) : (lbl == sel);
        b[i] = hit;
        exp_cnt += int'(hit);
      end
      exp_b[a] = b;
    end
  endtask

  function automatic int exp_pix(input int cnt);
`ifdef LABEL_PIX_COUNT_EN
    return cnt;
`else
    return 0 * cnt;
`endif
  endfunction

  task automatic fill_mem(input int pat);
    for (int n = 0; n < 1024; n++) begin
      case (pat)
        0:       mem[n] = 8'd0;
        1:       mem[n] = 8'(n % 4);
        2:       mem[n] = (n < 8) ? 8'd5 : 8'd7;
        default: mem[n] = 8'($urandom_range(0, 3));
      endcase
    end
  endtask

  logic [7:0] got_d [128];
  int n_wr, last_j, fin_j;

  // Cycle j of the frame is the j-th falling edge after the accepting rising edge
  task automatic run_frame(input logic [7:0] sel, input int repulse_j, input int reset_j);
    n_wr   = 0;
    last_j = -1;
    fin_j  = -1;
    for (int a = 0; a < 128; a++) got_d[a] = 8'hxx;
    @(negedge clk);
    sel_label = sel;
    start     = 1'b1;
    for (int j = 1; j <= 1040; j++) begin
      @(negedge clk);
      if (j == 1) begin
        start     = 1'b0;
        sel_label = 8'hA5;
        check("sram_a_first", 32'(sram_a), 32'd0);
        check("busy_run", 32'(busy), 32'd1);
        check("finish_clr", 32'(finish), 32'd0);
      end
      if (j == repulse_j) begin
        start     = 1'b1;
        sel_label = 8'd7;
      end
      if (j == repulse_j + 1) start = 1'b0;
      if (j == 1024) check("sram_a_last", 32'(sram_a), 32'd1023);
      if (j == reset_j) begin
        reset = 1'b0;
        #1;
        check("rst_out_wen", 32'(out_wen), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sram_a", 32'(sram_a), 32'd0);
        check("rst_finish", 32'(finish), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        begin
          int stray;
          stray = 0;
          repeat (20) begin
            @(negedge clk);
            if (!out_wen) stray++;
          end
          check("rst_no_writes", 32'(stray), 32'd0);
        end
        return;
      end
      if (!out_wen) begin
        if (n_wr < 128) begin
          check("write_addr", 32'(out_a), 32'(n_wr));
          got_d[n_wr] = out_d;
        end
        n_wr++;
        last_j = j;
      end
      if (finish && fin_j < 0) begin
        fin_j = j;
        check("busy_at_finish", 32'(busy), 32'd0);
      end
    end
    check("sram_a_no_wrap", 32'(sram_a), 32'd1023);
    check("finish_hold", 32'(finish), 32'd1);
  endtask

  task automatic verify_frame(input logic [7:0] sel);
    model(sel);
    check("write_count", 32'(n_wr), 32'd128);
    check("last_write_cycle", 32'(last_j), 32'd1026);
    check("finish_cycle", 32'(fin_j), 32'd1027);
    for (int a = 0; a < 128; a++) check("mask_byte", 32'(got_d[a]), 32'(exp_b[a]));
    check("pix_cnt", 32'(pix_cnt), 32'(exp_pix(exp_cnt)));
  endtask

  typedef struct {
    int         pat;
    logic [7:0] sel;
    logic [7:0] b0;
    logic [7:0] b_rest;
    int         cnt;
  } vec_t;

  vec_t vt [4];

  initial begin
    vt[0] = '{pat: 0, sel: 8'd0, b0: 8'h00, b_rest: 8'h00, cnt: 0};
    vt[1] = '{pat: 1, sel: 8'd1, b0: 8'h22, b_rest: 8'h22, cnt: 256};
    vt[2] = '{pat: 1, sel: 8'd0, b0: 8'hEE, b_rest: 8'hEE, cnt: 768};
    vt[3] = '{pat: 2, sel: 8'd5, b0: 8'hFF, b_rest: 8'h00, cnt: 8};

    reset     = 1'b0;
    start     = 1'b0;
    sel_label = 8'd0;
    fill_mem(0);
    repeat (3) @(negedge clk);
    check("rst_sram_a0", 32'(sram_a), 32'd0);
    check("rst_out_a0", 32'(out_a), 32'd0);
    check("rst_out_d0", 32'(out_d), 32'd0);
    check("rst_out_wen0", 32'(out_wen), 32'd1);
    check("rst_busy0", 32'(busy), 32'd0);
    check("rst_finish0", 32'(finish), 32'd0);
    check("rst_pix_cnt0", 32'(pix_cnt), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vt[v]) begin
      fill_mem(vt[v].pat);
      run_frame(vt[v].sel, -10, -10);
      check("vec_byte0", 32'(got_d[0]), 32'(vt[v].b0));
      for (int a = 1; a < 128; a++) check("vec_byte", 32'(got_d[a]), 32'(vt[v].b_rest));
      check("vec_pix_cnt", 32'(pix_cnt), 32'(exp_pix(vt[v].cnt)));
      verify_frame(vt[v].sel);
    end

    for (int r = 0; r < 4; r++) begin
      logic [7:0] s;
      fill_mem(3);
      s = 8'($urandom_range(0, 3));
      run_frame(s, -10, -10);
      verify_frame(s);
    end

    // start re-pulsed mid-run with a different label must be ignored
    fill_mem(1);
    run_frame(8'd1, 300, -10);
    verify_frame(8'd1);

    // reset mid-run, then a fresh frame must be complete and correct
    fill_mem(1);
    run_frame(8'd0, -10, 500);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_pix_cnt", 32'(pix_cnt), 32'd0);
    fill_mem(2);
    run_frame(8'd5, -10, -10);
    verify_frame(8'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
